// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if: requester-side handshake plus SDRAM controller command/data bus
interface sdram_port_arbiter_if #(
    parameter int AW = 25,
    parameter int DW = 16
);
    logic [2:0]          req;
    logic [2:0]          we;
    logic [3*AW-1:0]     addr;
    logic [3*DW-1:0]     wdata;
    logic [3*DW/8-1:0]   be;
    logic [2:0]          ack;
    logic [DW-1:0]       rdata;
    logic                err;
    logic                mem_req;
    logic                mem_we;
    logic [AW-1:0]       mem_addr;
    logic [DW-1:0]       mem_din;
    logic [DW/8-1:0]     mem_be;
    logic                mem_ack;
    logic                mem_rvalid;
    logic [DW-1:0]       mem_dout;
    modport master (
        output req, we, addr, wdata, be, mem_ack, mem_rvalid, mem_dout,
        input  ack, rdata, err, mem_req, mem_we, mem_addr, mem_din, mem_be
    );
    modport slave (
        input  req, we, addr, wdata, be, mem_ack, mem_rvalid, mem_dout,
        output ack, rdata, err, mem_req, mem_we, mem_addr, mem_din, mem_be
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: three-port arbiter onto one SDRAM controller port, port 0 priority with burst cap
module sdram_port_arbiter #(
    parameter int AW        = 25,
    parameter int DW        = 16,
    parameter int MAX_BURST = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    sdram_port_arbiter_if.slave  bus
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] WAIT_RD = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;
    logic [1:0]    state;
    logic [1:0]    grant;
    logic          rr_ptr;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wd_cnt;
    logic          any12;
    logic          p0_win;
    logic          sel2;
    logic [1:0]    gnt;
    logic [2:0]    gnt_1h;
    logic          rd_end;
    assign any12  = bus.req[1] | bus.req[2];
    // port 0 yields only once its burst cap is reached and someone else is waiting
    assign p0_win = bus.req[0] && !(burst_cnt == BW'(MAX_BURST) && any12);
    assign sel2   = (rr_ptr ? bus.req[2] : bus.req[1]) ? rr_ptr : !rr_ptr;
    assign gnt    = p0_win ? 2'd0 : (sel2 ? 2'd2 : 2'd1);
    assign gnt_1h = 3'b001 << grant;
    assign rd_end = bus.mem_rvalid || wd_cnt == WW'(TIMEOUT - 1);
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= 1'b0;
            burst_cnt    <= '0;
            wd_cnt       <= '0;
            bus.ack      <= '0;
            bus.rdata    <= '0;
            bus.err      <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.mem_be   <= '0;
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: if (|bus.req) begin
                    grant        <= gnt;
                    bus.mem_req  <= 1'b1;
                    bus.mem_we   <= bus.we[gnt];
                    bus.mem_addr <= bus.addr[gnt*AW +: AW];
                    bus.mem_din  <= bus.wdata[gnt*DW +: DW];
                    bus.mem_be   <= bus.be[gnt*(DW/8) +: DW/8];
                    burst_cnt    <= (p0_win && any12) ? burst_cnt + BW'(1) : '0;
                    rr_ptr       <= p0_win ? rr_ptr : !sel2;
                    state        <= ISSUE;
                end
                ISSUE: if (bus.mem_ack) begin
                    bus.mem_req <= 1'b0;
                    wd_cnt      <= '0;
                    // a read whose data arrives with the accept completes immediately
                    if (bus.mem_we || bus.mem_rvalid) begin
                        state   <= DONE;
                        bus.ack <= gnt_1h;
                        bus.err <= 1'b0;
                        if (!bus.mem_we) bus.rdata <= bus.mem_dout;
                    end else begin
                        state <= WAIT_RD;
                    end
                end
                WAIT_RD: if (rd_end) begin
                    state     <= DONE;
                    bus.ack   <= gnt_1h;
                    bus.err   <= !bus.mem_rvalid;
                    bus.rdata <= bus.mem_rvalid ? bus.mem_dout : '0;
                end else begin
                    wd_cnt <= wd_cnt + WW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed checks of arbitration order, read/write timing and read timeout
module tb_sdram_port_arbiter;
    localparam int AW = 25;
    localparam int DW = 16;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int macks;
    int c;
    logic [2:0] ack_log[$];
    sdram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    sdram_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(8), .TIMEOUT(64)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // controller stand-in: accepts each write the cycle after mem_req rises, logs acks
    task automatic run(input int n, output int nacc);
        int budget;
        budget = 0;
        nacc = 0;
        ack_log.delete();
        while (ack_log.size() < n && budget < 1000) begin
            bus.mem_ack = bus.mem_req && !bus.mem_ack;
            if (bus.mem_ack) nacc++;
            step();
            budget++;
            if (|bus.ack) ack_log.push_back(bus.ack);
        end
        bus.mem_ack = 1'b0;
        chk("run_ack_count", ack_log.size(), n);
    endtask

    initial begin
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be = '0;
        bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_dout = '0;
        #12;
        chk("rst_ack", bus.ack, 3'b000);
        chk("rst_mem_req", bus.mem_req, 1'b0);
        chk("rst_rdata", bus.rdata, 16'h0);
        chk("rst_err", bus.err, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 25'h0);
        reset_n = 1'b1;
        step();
        // single read on port 1
        bus.addr[AW +: AW] = 25'h12345;
        bus.req = 3'b010;
        step();
        chk("rd1_mem_req", bus.mem_req, 1'b1);
        chk("rd1_mem_addr", bus.mem_addr, 25'h12345);
        chk("rd1_mem_we", bus.mem_we, 1'b0);
        step();
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        chk("rd1_mem_req_drop", bus.mem_req, 1'b0);
        repeat (3) step();
        chk("rd1_no_early_ack", bus.ack, 3'b000);
        bus.mem_rvalid = 1'b1;
        bus.mem_dout = 16'hBEEF;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_dout = '0;
        bus.req = '0;
        chk("rd1_ack", bus.ack, 3'b010);
        chk("rd1_rdata", bus.rdata, 16'hBEEF);
        chk("rd1_err", bus.err, 1'b0);
        step();
        chk("rd1_ack_one_cycle", bus.ack, 3'b000);
        chk("rd1_rdata_hold", bus.rdata, 16'hBEEF);
        // asynchronous reset in the middle of a port-0 write
        bus.we = 3'b001;
        bus.addr[0 +: AW] = 25'h55;
        bus.wdata[0 +: DW] = 16'h1111;
        bus.be[1:0] = 2'b11;
        bus.req = 3'b001;
        step();
        chk("wr0_mem_req", bus.mem_req, 1'b1);
        chk("wr0_mem_we", bus.mem_we, 1'b1);
        chk("wr0_mem_din", bus.mem_din, 16'h1111);
        chk("wr0_mem_be", bus.mem_be, 2'b11);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_mem_req", bus.mem_req, 1'b0);
        chk("arst_ack", bus.ack, 3'b000);
        chk("arst_mem_addr", bus.mem_addr, 25'h0);
        bus.req = '0;
        step();
        reset_n = 1'b1;
        step();
        chk("arst_idle", bus.mem_req, 1'b0);
        chk("arst_no_ack", bus.ack, 3'b000);
        // ports 1 and 2 alternate
        bus.we = 3'b110;
        bus.req = 3'b110;
        run(4, macks);
        bus.req = '0;
        for (int i = 0; i < 4; i++) chk($sformatf("rr_ack%0d", i), ack_log[i], (i % 2 == 0) ? 3'b010 : 3'b100);
        chk("rr_one_ack_per_txn", macks, 4);
        repeat (2) step();
        // burst cap on port 0
        bus.we = 3'b111;
        bus.req = 3'b111;
        run(18, macks);
        bus.req = '0;
        for (int i = 0; i < 18; i++) chk($sformatf("burst_ack%0d", i), ack_log[i], (i == 8) ? 3'b010 : (i == 17) ? 3'b100 : 3'b001);
        chk("burst_one_ack_per_txn", macks, 18);
        repeat (2) step();
        // mem_ack and mem_rvalid together on a port-0 read
        bus.we = '0;
        bus.addr[0 +: AW] = 25'h0ABCD;
        bus.req = 3'b001;
        step();
        chk("fast_mem_addr", bus.mem_addr, 25'h0ABCD);
        bus.mem_ack = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_dout = 16'h00A5;
        step();
        bus.mem_ack = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_dout = '0;
        bus.req = '0;
        chk("fast_ack", bus.ack, 3'b001);
        chk("fast_rdata", bus.rdata, 16'h00A5);
        chk("fast_err", bus.err, 1'b0);
        chk("fast_mem_req", bus.mem_req, 1'b0);
        step();
        chk("fast_ack_one_cycle", bus.ack, 3'b000);
        // read timeout on port 2
        bus.addr[2*AW +: AW] = 25'h1F00;
        bus.req = 3'b100;
        step();
        chk("to_mem_req", bus.mem_req, 1'b1);
        chk("to_mem_addr", bus.mem_addr, 25'h1F00);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        c = 0;
        while (!(|bus.ack) && c < 200) begin
            step();
            c++;
        end
        bus.req = '0;
        chk("to_cycles", c, 64);
        chk("to_ack", bus.ack, 3'b100);
        chk("to_err", bus.err, 1'b1);
        chk("to_rdata", bus.rdata, 16'h0);
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_dout = 16'h1234;
        step();
        bus.mem_rvalid = 1'b0;
        bus.mem_dout = '0;
        chk("stray_ack", bus.ack, 3'b000);
        chk("stray_rdata", bus.rdata, 16'h0);
        chk("stray_mem_req", bus.mem_req, 1'b0);
        step();
        chk("stray_ack_later", bus.ack, 3'b000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
